// File: rtl/b06_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : b06_pkg
//  Description : Shared encodings for the b06 interrupt-handler controller:
//                state enum, cc_mux codes, uscite codes, output bundle type
//                and the reset output constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package b06_pkg;

  // Width of the state register; the controller checks its parameter against this.
  localparam int STATE_BITS = 3;

  // Controller states. Encoding 3'b111 is deliberately unused (illegal).
  typedef enum logic [STATE_BITS-1:0] {
    ST_INIT   = 3'b000,
    ST_WAIT   = 3'b001,
    ST_ENIN   = 3'b010,
    ST_ENIN_W = 3'b011,
    ST_INTR   = 3'b100,
    ST_INTR_1 = 3'b101,
    ST_INTR_W = 3'b110
  } state_e;

  // Counter mux select codes.
  localparam logic [1:0] CC_IDLE = 2'b00;
  localparam logic [1:0] CC_RUN  = 2'b01;
  localparam logic [1:0] CC_INT  = 2'b10;
  localparam logic [1:0] CC_CONT = 2'b11;

  // Handler result codes (2'b10 is never produced).
  localparam logic [1:0] US_NONE = 2'b00;
  localparam logic [1:0] US_INT  = 2'b01;
  localparam logic [1:0] US_RET  = 2'b11;

  // The six registered output bits, kept together so they share one register bank.
  typedef struct packed {
    logic [1:0] us;
    logic [1:0] cc;
    logic       en;
    logic       ack;
  } outs_t;

  // Output value sets that appear in the transition table.
  localparam outs_t OUT_RESET     = '{us: US_NONE, cc: CC_IDLE, en: 1'b0, ack: 1'b0};
  localparam outs_t OUT_RUN       = '{us: US_NONE, cc: CC_RUN,  en: 1'b1, ack: 1'b0};
  localparam outs_t OUT_RUN_ACK   = '{us: US_NONE, cc: CC_RUN,  en: 1'b1, ack: 1'b1};
  localparam outs_t OUT_INT_ENTRY = '{us: US_INT,  cc: CC_INT,  en: 1'b0, ack: 1'b1};
  localparam outs_t OUT_INT_RET   = '{us: US_RET,  cc: CC_RUN,  en: 1'b1, ack: 1'b0};

  // Interrupt-service outputs: cc follows the continuation flag.
  function automatic outs_t int_svc_outs(input logic cont_eql);
    outs_t o;
    o.us  = US_NONE;
    o.cc  = cont_eql ? CC_CONT : CC_RUN;
    o.en  = 1'b0;
    o.ack = 1'b1;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/b06_state_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : b06_state_ctrl_if
//  Description : Handshake bundle between the b06 state controller and the
//                counter datapath / combinational stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface b06_state_ctrl_if;

  logic       eql_pad;
  logic       cont_eql_pad;
  logic [2:0] state_q;
  logic [1:0] cc_mux_pad;
  logic [1:0] uscite_pad;
  logic       enable_count_pad;
  logic       ackout_pad;

  // Datapath side: drives the comparator flags, observes state and outputs.
  modport master (
    output eql_pad,
    output cont_eql_pad,
    input  state_q,
    input  cc_mux_pad,
    input  uscite_pad,
    input  enable_count_pad,
    input  ackout_pad
  );

  // Controller side.
  modport slave (
    input  eql_pad,
    input  cont_eql_pad,
    output state_q,
    output cc_mux_pad,
    output uscite_pad,
    output enable_count_pad,
    output ackout_pad
  );

endinterface
`default_nettype wire

// File: rtl/b06_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : b06_out_reg
//  Description : Register bank for the controller outputs with asynchronous,
//                active-low clear to a parameterised reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module b06_out_reg #(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_q
);

  // Output bank: cleared the moment reset asserts, otherwise loads every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/b06_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : b06_state_ctrl
//  Description : Sequential half of the b06 interrupt-handler controller.
//                Holds the state register and the registered Mealy outputs;
//                the single clocked boundary for eql/cont_eql handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module b06_state_ctrl
  import b06_pkg::*;
#(
  parameter int         STATE_W     = 3,
  parameter logic [2:0] RESET_STATE = 3'b000,
  parameter bit         ILLEGAL_RCV = 1'b1
) (
  input  logic            clock_pad,
  input  logic            reset_n_pad,
  b06_state_ctrl_if.slave bus
);

  // The encoding is fixed by the package; any other width is a build error.
  generate
    if (STATE_W != STATE_BITS) begin : g_state_w_bad
      $error("b06_state_ctrl: STATE_W must be %0d", STATE_BITS);
    end
  endgenerate

  state_e state_q;
  state_e state_d;
  outs_t  out_d;
  outs_t  out_q;

  // State register: async clear to the reset state, sync release.
  always_ff @(posedge clock_pad or negedge reset_n_pad) begin
    if (!reset_n_pad) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next registered outputs from the current state and the
  // flags sampled on this edge; outputs land together with the new state.
  always_comb begin
    state_d = state_q;
    out_d   = OUT_RESET;
    case (state_q)
      ST_INIT: begin
        state_d = ST_WAIT;
        out_d   = OUT_RUN;
      end
      ST_WAIT: begin
        if (bus.eql_pad) begin
          state_d = ST_ENIN;
          out_d   = OUT_RUN;
        end else begin
          state_d = ST_INTR_1;
          out_d   = OUT_INT_ENTRY;
        end
      end
      ST_ENIN, ST_ENIN_W: begin
        if (bus.eql_pad) begin
          state_d = ST_ENIN_W;
          out_d   = OUT_RUN_ACK;
        end else begin
          state_d = ST_INTR_1;
          out_d   = OUT_INT_ENTRY;
        end
      end
      ST_INTR_1: begin
        if (bus.eql_pad) begin
          state_d = ST_INTR;
          out_d   = int_svc_outs(bus.cont_eql_pad);
        end else begin
          state_d = ST_WAIT;
          out_d   = OUT_INT_RET;
        end
      end
      ST_INTR, ST_INTR_W: begin
        if (bus.eql_pad) begin
          state_d = ST_INTR_W;
          out_d   = int_svc_outs(bus.cont_eql_pad);
        end else begin
          state_d = ST_WAIT;
          out_d   = OUT_RUN;
        end
      end
      default: begin
        // Illegal encoding: outputs stay at reset values; optionally park.
        state_d = ILLEGAL_RCV ? ST_INIT : state_q;
        out_d   = OUT_RESET;
      end
    endcase
  end

  b06_out_reg #(
    .WIDTH     ($bits(outs_t)),
    .RESET_VAL (OUT_RESET)
  ) u_out_reg (
    .clk   (clock_pad),
    .rst_n (reset_n_pad),
    .out_d (out_d),
    .out_q (out_q)
  );

  assign bus.state_q          = state_q;
  assign bus.cc_mux_pad       = out_q.cc;
  assign bus.uscite_pad       = out_q.us;
  assign bus.enable_count_pad = out_q.en;
  assign bus.ackout_pad       = out_q.ack;

endmodule
`default_nettype wire

// File: tb/tb_b06_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_b06_state_ctrl
//  Description : Self-checking bench for b06_state_ctrl: directed scenarios
//                followed by random eql/cont_eql/reset traffic compared
//                against a table-driven reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_b06_state_ctrl;

  // Reference encodings (independent of the design package).
  localparam int M_INIT = 0, M_WAIT = 1, M_ENIN = 2, M_ENIN_W = 3;
  localparam int M_INTR = 4, M_INTR_1 = 5, M_INTR_W = 6;

  // Destination tables indexed by current state.
  localparam int NXT_EQ [7] = '{M_WAIT, M_ENIN, M_ENIN_W, M_ENIN_W, M_INTR_W, M_INTR, M_INTR_W};
  localparam int NXT_NE [7] = '{M_WAIT, M_INTR_1, M_INTR_1, M_INTR_1, M_WAIT, M_WAIT, M_WAIT};

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_st, m_cc, m_us, m_en, m_ack;

  b06_state_ctrl_if bus ();

  b06_state_ctrl #(
    .STATE_W     (3),
    .RESET_STATE (3'b000),
    .ILLEGAL_RCV (1'b1)
  ) dut (
    .clock_pad   (clk),
    .reset_n_pad (rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int st, input int us, input int cc,
                         input int en, input int ack);
    chk({tag, ".state"}, 8'(bus.state_q),          8'(st));
    chk({tag, ".us"},    8'(bus.uscite_pad),       8'(us));
    chk({tag, ".cc"},    8'(bus.cc_mux_pad),       8'(cc));
    chk({tag, ".en"},    8'(bus.enable_count_pad), 8'(en));
    chk({tag, ".ack"},   8'(bus.ackout_pad),       8'(ack));
  endtask

  // One clock: inputs change at the falling edge, results sampled after the rise.
  task automatic step(input logic e, input logic c);
    @(negedge clk);
    bus.eql_pad      = e;
    bus.cont_eql_pad = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: outputs derived from where the transition lands.
  task automatic model_step(input bit e, input bit c);
    int src;
    src  = m_st;
    m_st = e ? NXT_EQ[src] : NXT_NE[src];
    m_en  = (m_st == M_WAIT || m_st == M_ENIN || m_st == M_ENIN_W) ? 1 : 0;
    m_ack = (m_st == M_ENIN_W || m_st == M_INTR_1 || m_st == M_INTR || m_st == M_INTR_W) ? 1 : 0;
    if (m_st == M_INTR_1)                       m_cc = 2;
    else if (m_st == M_INTR || m_st == M_INTR_W) m_cc = c ? 3 : 1;
    else                                        m_cc = 1;
    if (m_st == M_INTR_1)                       m_us = 1;
    else if (src == M_INTR_1 && m_st == M_WAIT) m_us = 3;
    else                                        m_us = 0;
  endtask

  task automatic model_reset();
    m_st = M_INIT; m_us = 0; m_cc = 0; m_en = 0; m_ack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    bus.eql_pad      = 1'b0;
    bus.cont_eql_pad = 1'b0;

    // Reset held with clocks running.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", M_INIT, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Power-up walk with eql held high.
    step(1'b1, 1'b0); chk_all("up_wait",   M_WAIT,   0, 1, 1, 0);
    step(1'b1, 1'b0); chk_all("up_enin",   M_ENIN,   0, 1, 1, 0);
    step(1'b1, 1'b0); chk_all("up_enin_w", M_ENIN_W, 0, 1, 1, 1);

    // Interrupt entry, immediate return with result code 11.
    step(1'b0, 1'b1); chk_all("enw_intr1", M_INTR_1, 1, 2, 0, 1);
    step(1'b0, 1'b0); chk_all("intr1_ret", M_WAIT,   3, 1, 1, 0);

    // Interrupt entry then continuation service.
    step(1'b0, 1'b0); chk_all("wait_intr1", M_INTR_1, 1, 2, 0, 1);
    step(1'b1, 1'b1); chk_all("intr_cont",  M_INTR,   0, 3, 0, 1);
    step(1'b1, 1'b1); chk_all("intrw_cont", M_INTR_W, 0, 3, 0, 1);
    step(1'b1, 1'b0); chk_all("intrw_run",  M_INTR_W, 0, 1, 0, 1);
    step(1'b0, 1'b1); chk_all("intrw_ret",  M_WAIT,   0, 1, 1, 0);

    // Illegal encoding via backdoor recovers to INIT with reset outputs.
    @(negedge clk);
    force dut.state_q = b06_pkg::state_e'(3'b111);
    #1;
    chk("illegal.forced", 8'(bus.state_q), 8'd7);
    release dut.state_q;
    bus.eql_pad = 1'b1;
    @(posedge clk);
    #1;
    chk_all("illegal_rcv", M_INIT, 0, 0, 0, 0);
    step(1'b1, 1'b0); chk_all("illegal_wait", M_WAIT, 0, 1, 1, 0);

    // Asynchronous reset in the middle of a cycle while in ENIN_W.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk_all("pre_arst", M_ENIN_W, 0, 1, 1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst_now", M_INIT, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("arst_hold", M_INIT, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0); chk_all("arst_rel", M_WAIT, 0, 1, 1, 0);

    // Random traffic against the reference model.
    m_st = M_WAIT; m_us = 0; m_cc = 1; m_en = 1; m_ack = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("rnd_rst", m_st, m_us, m_cc, m_en, m_ack);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        logic e, c;
        e = 1'($urandom_range(0, 3) != 0);
        c = 1'($urandom);
        step(e, c);
        model_step(e, c);
        chk_all("rnd", m_st, m_us, m_cc, m_en, m_ack);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
